// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmitter: FSM states,
// SYNC pattern, bit-stuffing limit, EOP length and line encodings.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

  // Line states as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_nrzi.sv
// Bit stuffer and NRZI line encoder. Each tick emits one line bit; when six
// ones have gone out, stall is raised and the next tick sends a stuffed 0.
module usb_tx_nrzi
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic data_bit,
  input  logic se0,
  input  logic force_j,
  output logic dp,
  output logic dm,
  output logic stall
);

  localparam logic [2:0] STUFF_MAX = 3'(STUFF_LIMIT);

  logic       lvl_j;
  logic [2:0] ones;

  assign stall = (ones == STUFF_MAX);

  // force_j parks the encoder at J with a cleared run count, so every packet
  // starts its NRZI sequence from J.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_j    <= 1'b1;
      ones     <= '0;
      {dp, dm} <= LINE_J;
    end else if (force_j) begin
      lvl_j    <= 1'b1;
      ones     <= '0;
      {dp, dm} <= LINE_J;
    end else if (se0) begin
      ones     <= '0;
      {dp, dm} <= LINE_SE0;
    end else if (tick) begin
      if (stall || !data_bit) begin
        lvl_j    <= !lvl_j;
        ones     <= '0;
        {dp, dm} <= lvl_j ? LINE_K : LINE_J;
      end else begin
        ones     <= ones + 3'd1;
        {dp, dm} <= lvl_j ? LINE_J : LINE_K;
      end
    end
  end

endmodule

// File: rtl/usb_fs_tx.sv
// USB full-speed packet transmitter: one-byte holding register, packet FSM
// and bit timer; stuffing and NRZI are delegated to usb_tx_nrzi.
module usb_fs_tx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dm,
  output logic       oe,
  output logic       busy,
  output logic       underrun
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    SE0_LAST = 3'(EOP_SE0_BITS - 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    next_idx;
  logic [7:0]    shreg;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          hold_last;
  logic          cur_last;
  logic          last_taken;

  logic tick;
  logic stall;
  logic start;
  logic in_byte;
  logic byte_end;
  logic drain;
  logic eop_go;
  logic underrun_go;
  logic accept;
  logic line_tick;
  logic line_bit;
  logic line_se0;
  logic line_j;

  assign tick        = (state != ST_IDLE) && (cnt == CNT_MAX);
  assign start       = (state == ST_IDLE) && hold_full;
  assign in_byte     = (state == ST_SYNC) || (state == ST_DATA);
  assign next_idx    = bit_idx + 3'd1;
  assign byte_end    = in_byte && tick && !stall && (bit_idx == 3'd7);
  assign drain       = byte_end && hold_full && !((state == ST_DATA) && cur_last);
  assign underrun_go = byte_end && !hold_full && !((state == ST_DATA) && cur_last);
  assign eop_go      = byte_end && !drain;

  // Ready also while draining, so a new byte can load on the same edge.
  assign tx_ready = (!hold_full || drain) && !last_taken;
  assign accept   = tx_valid && tx_ready;

  assign line_tick = start || (in_byte && tick && !eop_go);
  assign line_se0  = eop_go;
  assign line_j    = ((state == ST_IDLE) && !hold_full)
                  || ((state == ST_EOP_SE0) && tick && (bit_idx == SE0_LAST))
                  || ((state == ST_EOP_J) && tick);

  always_comb begin
    line_bit = 1'b0;
    if (start)
      line_bit = SYNC_PATTERN[0];
    else if (drain)
      line_bit = hold_data[0];
    else if (state == ST_SYNC)
      line_bit = SYNC_PATTERN[next_idx];
    else if (state == ST_DATA)
      line_bit = shreg[next_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      last_taken <= 1'b0;
    end else begin
      if (accept) begin
        hold_full <= 1'b1;
        hold_last <= tx_last;
      end else if (drain) begin
        hold_full <= 1'b0;
      end
      if ((state == ST_EOP_J) && tick)
        last_taken <= 1'b0;
      if (accept && tx_last)
        last_taken <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      hold_data <= tx_data;
    if (drain)
      shreg <= hold_data;
  end

  // bit_idx is the bit currently on the line in SYNC/DATA, and the SE0 bit
  // count during EOP. A stall holds it so the stuffed bit takes a full slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      cur_last <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= underrun_go;
      cnt      <= ((state == ST_IDLE) || tick) ? '0 : cnt + CW'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SYNC;
            bit_idx <= '0;
            oe      <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_SYNC, ST_DATA: begin
          if (byte_end) begin
            bit_idx <= '0;
            if (drain) begin
              state    <= ST_DATA;
              cur_last <= hold_last;
            end else begin
              state <= ST_EOP_SE0;
            end
          end else if (tick && !stall) begin
            bit_idx <= next_idx;
          end
        end
        ST_EOP_SE0: begin
          if (tick) begin
            if (bit_idx == SE0_LAST) begin
              state   <= ST_EOP_J;
              bit_idx <= '0;
            end else begin
              bit_idx <= next_idx;
            end
          end
        end
        ST_EOP_J: begin
          if (tick) begin
            state <= ST_IDLE;
            oe    <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  usb_tx_nrzi u_nrzi (
    .clk     (clk),
    .rst     (rst),
    .tick    (line_tick),
    .data_bit(line_bit),
    .se0     (line_se0),
    .force_j (line_j),
    .dp      (dp),
    .dm      (dm),
    .stall   (stall)
  );

endmodule

// File: tb/tb_usb_fs_tx.sv
// Bench for usb_fs_tx: packets are compared bit-time by bit-time against a
// reference line sequence built from SYNC, stuffing and NRZI rules.
module tb_usb_fs_tx;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       sel5;

  logic v4, ready4, dp4, dm4, oe4, busy4, ur4;
  logic v5, ready5, dp5, dm5, oe5, busy5, ur5;
  logic m_ready, m_dp, m_dm, m_oe, m_busy, m_underrun;

  int total;
  int bad;
  int cpb;

  logic [7:0] pkt[$];
  logic [1:0] exp_sym[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign v4 = tx_valid & ~sel5;
  assign v5 = tx_valid & sel5;

  assign m_ready    = sel5 ? ready5 : ready4;
  assign m_dp       = sel5 ? dp5 : dp4;
  assign m_dm       = sel5 ? dm5 : dm4;
  assign m_oe       = sel5 ? oe5 : oe4;
  assign m_busy     = sel5 ? busy5 : busy4;
  assign m_underrun = sel5 ? ur5 : ur4;

  usb_fs_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .tx_valid(v4), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(ready4), .dp(dp4), .dm(dm4), .oe(oe4), .busy(busy4), .underrun(ur4)
  );

  usb_fs_tx #(.CLKS_PER_BIT(5)) dut5 (
    .clk(clk), .rst(rst), .tx_valid(v5), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(ready5), .dp(dp5), .dm(dm5), .oe(oe5), .busy(busy5), .underrun(ur5)
  );

  // Expected line symbols ({dp,dm}) for the first n_bytes of pkt.
  function automatic void build_model(input int n_bytes);
    logic raw[$];
    logic stuffed[$];
    int   ones;
    logic lvl_j;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    for (int k = 0; k < n_bytes; k++)
      for (int i = 0; i < 8; i++) raw.push_back(pkt[k][i]);
    ones = 0;
    foreach (raw[i]) begin
      stuffed.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        stuffed.push_back(1'b0);
        ones = 0;
      end
    end
    exp_sym.delete();
    lvl_j = 1'b1;
    foreach (stuffed[i]) begin
      if (!stuffed[i]) lvl_j = !lvl_j;
      exp_sym.push_back(lvl_j ? 2'b10 : 2'b01);
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endfunction

  task automatic run_packet(input string name, input int n_send, input bit with_last,
                            input int exp_ur, input int gap_max);
    int ur_cnt;
    int rdy_viol;
    bit last_acc;
    build_model(n_send);
    ur_cnt   = 0;
    rdy_viol = 0;
    last_acc = 1'b0;
    fork
      begin
        for (int k = 0; k < n_send; k++) begin
          int w;
          w = 0;
          tx_data  = pkt[k];
          tx_last  = with_last && (k == n_send - 1);
          tx_valid = 1'b1;
          while (m_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
          end
          total++;
          if (m_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept%0d: tx_ready=%b want 1 within 2000 clks", name, k, m_ready);
            tx_valid = 1'b0;
            break;
          end
          @(negedge clk);
          tx_valid = 1'b0;
          tx_last  = 1'b0;
          if (with_last && (k == n_send - 1)) last_acc = 1'b1;
          if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
      end
      begin
        int         waited;
        bit         ok;
        logic [2:0] got;
        waited = 0;
        while (m_oe !== 1'b1 && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        total++;
        if (m_oe !== 1'b1) begin
          bad++;
          $display("FAIL %s oe_start: oe=%b want 1 within 400 clks", name, m_oe);
        end else begin
          foreach (exp_sym[s]) begin
            ok  = 1'b1;
            got = 3'b000;
            for (int c = 0; c < cpb; c++) begin
              if ({m_oe, m_dp, m_dm} !== {1'b1, exp_sym[s]}) begin
                if (ok) got = {m_oe, m_dp, m_dm};
                ok = 1'b0;
              end
              if (m_underrun === 1'b1) ur_cnt++;
              if (last_acc && m_ready !== 1'b0) rdy_viol++;
              @(negedge clk);
            end
            total++;
            if (!ok) begin
              bad++;
              $display("FAIL %s sym%0d: oe/dp/dm=%b want %b", name, s, got, {1'b1, exp_sym[s]});
            end
          end
          total++;
          if ({m_oe, m_dp, m_dm, m_busy, m_ready} !== 5'b01001) begin
            bad++;
            $display("FAIL %s idle: oe/dp/dm/busy/rdy=%b want 01001", name,
                     {m_oe, m_dp, m_dm, m_busy, m_ready});
          end
        end
      end
    join
    total++;
    if (ur_cnt !== exp_ur) begin
      bad++;
      $display("FAIL %s underrun_count: got %0d want %0d", name, ur_cnt, exp_ur);
    end
    if (with_last) begin
      total++;
      if (rdy_viol !== 0) begin
        bad++;
        $display("FAIL %s ready_after_last: high for %0d clks want 0", name, rdy_viol);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({m_ready, m_dp, m_dm, m_oe, m_busy, m_underrun} !== 6'b110000) begin
      bad++;
      $display("FAIL reset4: rdy/dp/dm/oe/busy/ur=%b want 110000",
               {m_ready, m_dp, m_dm, m_oe, m_busy, m_underrun});
    end
    total++;
    if ({ready5, dp5, dm5, oe5, busy5, ur5} !== 6'b110000) begin
      bad++;
      $display("FAIL reset5: rdy/dp/dm/oe/busy/ur=%b want 110000",
               {ready5, dp5, dm5, oe5, busy5, ur5});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_byte();
    pkt = '{8'h00};
    run_packet("zero_byte", 1, 1'b1, 0, 0);
  endtask

  task automatic test_ff_stuff();
    pkt = '{8'hFF};
    run_packet("ff_stuff", 1, 1'b1, 0, 0);
  endtask

  task automatic test_back_to_back();
    pkt = '{8'hA5, 8'h3C};
    run_packet("back_to_back", 2, 1'b1, 0, 0);
  endtask

  task automatic test_underrun();
    pkt = '{8'h5A, 8'h11};
    run_packet("underrun", 1, 1'b0, 1, 0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int n;
      n = $urandom_range(4, 1);
      pkt.delete();
      for (int k = 0; k < n; k++)
        pkt.push_back(($urandom_range(2, 0) == 0) ? 8'hFF : 8'($urandom));
      run_packet($sformatf("rand%0d", p), n, 1'b1, 0, 3);
    end
  endtask

  task automatic test_reset_mid();
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (48) @(negedge clk);
    total++;
    if ({m_oe, m_busy} !== 2'b11) begin
      bad++;
      $display("FAIL pre_rst: oe/busy=%b want 11", {m_oe, m_busy});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({m_ready, m_dp, m_dm, m_oe, m_busy, m_underrun} !== 6'b110000) begin
      bad++;
      $display("FAIL rst_mid: rdy/dp/dm/oe/busy/ur=%b want 110000",
               {m_ready, m_dp, m_dm, m_oe, m_busy, m_underrun});
    end
    @(negedge clk);
    total++;
    if ({m_ready, m_dp, m_dm, m_oe, m_busy} !== 5'b11000) begin
      bad++;
      $display("FAIL rst_hold: rdy/dp/dm/oe/busy=%b want 11000",
               {m_ready, m_dp, m_dm, m_oe, m_busy});
    end
    rst = 1'b0;
    @(negedge clk);
    pkt = '{8'h3C};
    run_packet("after_rst", 1, 1'b1, 0, 0);
  endtask

  task automatic test_cpb5();
    sel5 = 1'b1;
    cpb  = 5;
    @(negedge clk);
    pkt = '{8'h00};
    run_packet("cpb5_zero", 1, 1'b1, 0, 0);
    pkt = '{8'hFF, 8'h7E};
    run_packet("cpb5_stuff", 2, 1'b1, 0, 0);
    sel5 = 1'b0;
    cpb  = 4;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cpb      = 4;
    sel5     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    rst      = 1'b0;
    test_reset();
    test_zero_byte();
    test_ff_stuff();
    test_back_to_back();
    test_underrun();
    test_random();
    test_reset_mid();
    test_cpb5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 2000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
